uart_tx_scheduler: RTL and testbench

- Schedules and arbitrates the byte-wide UART transmit path between two requesters: the miner nonce reporter (framed 4-byte nonce) and the host status/ack reporter (single byte).
- Sits between the result logic and the UART module's din/wr_en/tx_busy interface.
- Replaces ad-hoc byte counting with a single FSM.
- Adds frame start bytes, busy-edge handshaking with a timeout, round-robin arbitration and overrun detection.

---
 rtl/uart_tx_scheduler.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_scheduler : round-robin byte scheduler for nonce frames and status |
// | bytes toward a UART din/wr_en/tx_busy port.            Revision: 1.0       |
// +----------------------------------------------------------------------------+
module uart_tx_scheduler #(
  parameter logic [7:0]  SOF_BYTE     = 8'hAA,
  parameter int unsigned NONCE_BYTES  = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        nonce_valid_i,
  input  logic [31:0] nonce_in_i,
  input  logic        status_valid_i,
  input  logic [7:0]  status_in_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_en_o,
  output logic        sched_busy_o,
  output logic        nonce_done_o,
  output logic        status_done_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_e;

  localparam logic [2:0] c_nonce_cnt = 3'(NONCE_BYTES + 1);
  localparam logic [7:0] c_tmo_last  = 8'(BUSY_TIMEOUT - 1);

  state_e      state_q;
  logic        last_grant_nonce_q;
  logic [31:0] shift_q;
  logic [2:0]  byte_cnt_q;
  logic [7:0]  tmo_cnt_q;
  logic [7:0]  tx_data_q;
  logic        tx_wr_en_q;
  logic        nonce_done_q;
  logic        status_done_q;

  logic        nonce_pend_q, nonce_pend_d;
  logic [31:0] nonce_hold_q, nonce_hold_d;
  logic        status_pend_q, status_pend_d;
  logic [7:0]  status_hold_q, status_hold_d;
  logic        overrun_q, overrun_d;

  logic        grant_nonce;
  logic        grant_status;

  // A tie goes to the requester that did not win last time.
  always_comb begin
    grant_nonce  = 1'b0;
    grant_status = 1'b0;
    if (state_q == S_IDLE && !tx_busy_i) begin
      if (nonce_pend_q && (!status_pend_q || !last_grant_nonce_q)) begin
        grant_nonce = 1'b1;
      end else if (status_pend_q) begin
        grant_status = 1'b1;
      end
    end
  end

  always_comb begin
    nonce_pend_d  = nonce_pend_q;
    nonce_hold_d  = nonce_hold_q;
    status_pend_d = status_pend_q;
    status_hold_d = status_hold_q;
    overrun_d     = overrun_q;
    if (grant_nonce)  nonce_pend_d  = 1'b0;
    if (grant_status) status_pend_d = 1'b0;
    // A request landing on the very cycle its predecessor is granted is not lost.
    if (nonce_valid_i) begin
      nonce_hold_d = nonce_in_i;
      nonce_pend_d = 1'b1;
      if (nonce_pend_q && !grant_nonce) overrun_d = 1'b1;
    end
    if (status_valid_i) begin
      status_hold_d = status_in_i;
      status_pend_d = 1'b1;
      if (status_pend_q && !grant_status) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      nonce_pend_q  <= 1'b0;
      nonce_hold_q  <= 32'h0;
      status_pend_q <= 1'b0;
      status_hold_q <= 8'h0;
      overrun_q     <= 1'b0;
    end else begin
      nonce_pend_q  <= nonce_pend_d;
      nonce_hold_q  <= nonce_hold_d;
      status_pend_q <= status_pend_d;
      status_hold_q <= status_hold_d;
      overrun_q     <= overrun_d;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q            <= S_IDLE;
      last_grant_nonce_q <= 1'b0;
      shift_q            <= 32'h0;
      byte_cnt_q         <= 3'd0;
      tmo_cnt_q          <= 8'd0;
      tx_data_q          <= 8'h0;
      tx_wr_en_q         <= 1'b0;
      nonce_done_q       <= 1'b0;
      status_done_q      <= 1'b0;
    end else begin
      tx_wr_en_q    <= 1'b0;
      nonce_done_q  <= 1'b0;
      status_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_nonce) begin
            last_grant_nonce_q <= 1'b1;
            shift_q            <= nonce_hold_q;
            byte_cnt_q         <= c_nonce_cnt;
            tx_data_q          <= SOF_BYTE;
            tx_wr_en_q         <= 1'b1;
            state_q            <= S_STROBE;
          end else if (grant_status) begin
            last_grant_nonce_q <= 1'b0;
            shift_q            <= 32'h0;
            byte_cnt_q         <= 3'd1;
            tx_data_q          <= status_hold_q;
            tx_wr_en_q         <= 1'b1;
            state_q            <= S_STROBE;
          end
        end
        S_STROBE: begin
          tmo_cnt_q <= 8'd0;
          state_q   <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // A UART that never raises busy is assumed to have taken the byte.
          if (tx_busy_i || tmo_cnt_q == c_tmo_last) begin
            state_q <= S_WAIT_LO;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy_i) begin
            byte_cnt_q <= byte_cnt_q - 3'd1;
            if (byte_cnt_q == 3'd1) begin
              nonce_done_q  <= last_grant_nonce_q;
              status_done_q <= !last_grant_nonce_q;
              state_q       <= S_IDLE;
            end else begin
              tx_data_q  <= shift_q[31:24];
              shift_q    <= {shift_q[23:0], 8'h00};
              tx_wr_en_q <= 1'b1;
              state_q    <= S_STROBE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_wr_en_o    = tx_wr_en_q;
  assign sched_busy_o  = (state_q != S_IDLE);
  assign nonce_done_o  = nonce_done_q;
  assign status_done_o = status_done_q;
  assign overrun_o     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_scheduler : directed bench with a simple UART busy model.       |
// |                                                        Revision: 1.0       |
// +----------------------------------------------------------------------------+
module tb_uart_tx_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        nonce_valid = 1'b0;
  logic [31:0] nonce_in = 32'h0;
  logic        status_valid = 1'b0;
  logic [7:0]  status_in = 8'h0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        sched_busy;
  logic        nonce_done;
  logic        status_done;
  logic        overrun;

  uart_tx_scheduler dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .nonce_valid_i  (nonce_valid),
    .nonce_in_i     (nonce_in),
    .status_valid_i (status_valid),
    .status_in_i    (status_in),
    .tx_busy_i      (tx_busy),
    .tx_data_o      (tx_data),
    .tx_wr_en_o     (tx_wr_en),
    .sched_busy_o   (sched_busy),
    .nonce_done_o   (nonce_done),
    .status_done_o  (status_done),
    .overrun_o      (overrun)
  );

  initial forever #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] cap[$];
  int nonce_done_n, status_done_n;
  int first_strobe_cyc, last_strobe_cyc, nonce_done_cyc, status_done_cyc;
  bit uart_en = 1'b1;
  int hold = 0;
  bit start_pend = 1'b0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Log of everything the DUT sends
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (tx_wr_en) begin
        if (cap.size() == 0) first_strobe_cyc = cyc;
        last_strobe_cyc = cyc;
        cap.push_back(tx_data);
      end
      if (nonce_done) begin
        nonce_done_n++;
        nonce_done_cyc = cyc;
      end
      if (status_done) begin
        status_done_n++;
        status_done_cyc = cyc;
      end
    end
  end

  // UART model: busy rises one cycle after a strobe and stays high 10 cycles
  initial forever begin
    @(negedge clock);
    if (reset || !uart_en) begin
      tx_busy = 1'b0;
      hold = 0;
      start_pend = 1'b0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) tx_busy = 1'b0;
      end else if (start_pend) begin
        tx_busy = 1'b1;
        hold = 10;
        start_pend = 1'b0;
      end
      if (tx_wr_en) start_pend = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(posedge clock);
    cap.delete();
    nonce_done_n = 0;
    status_done_n = 0;
    first_strobe_cyc = -1;
    last_strobe_cyc = -1;
    nonce_done_cyc = -1;
    status_done_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_nonce(input logic [31:0] v, output int c);
    @(negedge clock);
    nonce_valid = 1'b1;
    nonce_in = v;
    c = cyc;
    @(negedge clock);
    nonce_valid = 1'b0;
  endtask

  task automatic send_status(input logic [7:0] v, output int c);
    @(negedge clock);
    status_valid = 1'b1;
    status_in = v;
    c = cyc;
    @(negedge clock);
    status_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int bound);
    int q = 0;
    for (int i = 0; i < bound && q < 4; i++) begin
      @(negedge clock);
      if (!sched_busy) q++;
      else q = 0;
    end
    if (q < 4) check({tag, "_quiet_timeout"}, q, 4);
  endtask

  task automatic wait_cap(input string tag, input int k, input int bound);
    for (int i = 0; i < bound && cap.size() < k; i++) @(posedge clock);
    if (cap.size() < k) check({tag, "_cap_timeout"}, cap.size(), k);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, cap.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), (i < cap.size()) ? cap[i] : 8'hxx, exp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    bit hit;

    // Reset state and a single nonce frame
    do_reset();
    @(negedge clock);
    check("rst_wr_en", tx_wr_en, 0);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tx_data", tx_data, 0);
    clear_log();
    send_nonce(32'h12345678, c);
    wait_quiet("single", 400);
    check_bytes("single", '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78});
    check("single_first_strobe", first_strobe_cyc, c + 2);
    check("single_done_n", nonce_done_n, 1);
    check("single_done_cyc", nonce_done_cyc, last_strobe_cyc + 12);
    check("single_status_done_n", status_done_n, 0);
    check("single_sched_busy", sched_busy, 0);

    // Arbitration: tie goes to nonce after reset, then alternate
    do_reset();
    clear_log();
    @(negedge clock);
    nonce_valid = 1'b1;
    nonce_in = 32'hDEADBEEF;
    status_valid = 1'b1;
    status_in = 8'h5A;
    @(negedge clock);
    nonce_valid = 1'b0;
    status_valid = 1'b0;
    repeat (6) @(negedge clock);
    send_nonce(32'h01020304, c);
    wait_cap("arb", 6, 400);
    send_status(8'h11, c);
    wait_quiet("arb", 1500);
    check_bytes("arb", '{8'hAA, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h5A,
                         8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11});
    check("arb_overrun", overrun, 0);
    check("arb_nonce_done_n", nonce_done_n, 2);
    check("arb_status_done_n", status_done_n, 2);

    // Overrun: second status overwrites the first while the nonce frame runs
    do_reset();
    clear_log();
    send_nonce(32'hCAFEF00D, c);
    repeat (3) @(negedge clock);
    send_status(8'h01, c);
    repeat (2) @(negedge clock);
    send_status(8'h02, c);
    check("ovr_flag_mid", overrun, 1);
    wait_quiet("ovr", 800);
    check_bytes("ovr", '{8'hAA, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h02});
    check("ovr_flag_end", overrun, 1);
    check("ovr_status_done_n", status_done_n, 1);
    check("ovr_nonce_done_n", nonce_done_n, 1);

    // Busy timeout: UART never responds
    do_reset();
    uart_en = 1'b0;
    clear_log();
    send_status(8'h33, c);
    wait_quiet("tmo", 200);
    check_bytes("tmo", '{8'h33});
    check("tmo_first_strobe", first_strobe_cyc, c + 2);
    check("tmo_done_latency", status_done_cyc - first_strobe_cyc, 18);
    check("tmo_status_done_n", status_done_n, 1);
    check("tmo_sched_busy", sched_busy, 0);
    uart_en = 1'b1;

    // Asynchronous reset during the third strobe of a nonce frame
    do_reset();
    clear_log();
    send_nonce(32'h55667788, c);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clock);
      #1;
      if (tx_wr_en && cap.size() == 2) hit = 1'b1;
    end
    check("rstmid_reached", hit, 1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_wr_en", tx_wr_en, 0);
    check("rstmid_sched_busy", sched_busy, 0);
    check("rstmid_nonce_done", nonce_done, 0);
    check("rstmid_status_done", status_done, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    n = cap.size();
    repeat (40) @(negedge clock);
    check("rstmid_no_strobes", cap.size(), n);
    check("rstmid_idle", sched_busy, 0);
    clear_log();
    send_nonce(32'h9ABCDEF0, c);
    wait_quiet("rstnew", 400);
    check_bytes("rstnew", '{8'hAA, 8'h9A, 8'hBC, 8'hDE, 8'hF0});
    check("rstnew_done_n", nonce_done_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
